// File: rtl/board_pixel_gen_if.sv
// Pixel-renderer bus: raster/timing inputs, board-memory write port,
// cursor/selection controls and the re-aligned video outputs.
interface board_pixel_gen_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        in_de;
  logic        hsync_in;
  logic        vsync_in;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [5:0]  cursor_addr;
  logic        sel_valid;
  logic [5:0]  sel_addr;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic        frame_tick;

  modport master (
    output pix_x, pix_y, in_de, hsync_in, vsync_in,
    output wr_en, wr_addr, wr_data, cursor_addr, sel_valid, sel_addr,
    input  rgb_out, hsync_out, vsync_out, de_out, frame_tick
  );

  modport slave (
    input  pix_x, pix_y, in_de, hsync_in, vsync_in,
    input  wr_en, wr_addr, wr_data, cursor_addr, sel_valid, sel_addr,
    output rgb_out, hsync_out, vsync_out, de_out, frame_tick
  );
endinterface

// File: rtl/board_pixel_gen.sv
// Chessboard pixel renderer: tracks the 60x60 cell under the raster without
// a divider, reads the 64-square board memory and muxes cursor, pieces,
// selection and square colours into 12-bit RGB, three clocks behind the
// raster inputs with syncs and display-enable kept aligned.
module board_pixel_gen #(
  parameter int          BOARD_X0  = 80,
  parameter int          BOARD_Y0  = 0,
  parameter int          BLINK_BIT = 4,
  parameter logic [11:0] LIGHT_RGB = 12'hEDB,
  parameter logic [11:0] DARK_RGB  = 12'h964
) (
  input logic              clk,
  input logic              reset,
  board_pixel_gen_if.slave bus
);

  localparam logic [9:0] X0 = 10'(BOARD_X0);
  localparam logic [9:0] Y0 = 10'(BOARD_Y0);

  // Standard opening position; bit3 set marks black pieces.
  function automatic logic [3:0] start_piece(input logic [5:0] idx);
    logic [2:0] back;
    case (idx[2:0])
      3'd0, 3'd7: back = 3'd4;
      3'd1, 3'd6: back = 3'd2;
      3'd2, 3'd5: back = 3'd3;
      3'd3:       back = 3'd5;
      default:    back = 3'd6;
    endcase
    case (idx[5:3])
      3'd0:    return {1'b1, back};
      3'd1:    return 4'h9;
      3'd6:    return 4'h1;
      3'd7:    return {1'b0, back};
      default: return 4'h0;
    endcase
  endfunction

  // Piece glyph is a centred square whose margin shrinks with piece rank.
  function automatic logic piece_hit(input logic [2:0] t, input logic [5:0] sx,
                                     input logic [5:0] sy);
    logic [5:0] m;
    if (t == 3'd0 || t == 3'd7) return 1'b0;
    m = 6'd22 - {2'b00, t, 1'b0};
    return (sx >= m) && (sx <= 6'd59 - m) && (sy >= m) && (sy <= 6'd59 - m);
  endfunction

  // Three-pixel frame around the cell edge used by the cursor outline.
  function automatic logic edge_band(input logic [5:0] s);
    return (s <= 6'd2) || (s >= 6'd57);
  endfunction

  logic [3:0]  mem_q [64];
  logic [5:0]  subx_q, subx_d, suby_q, suby_d;
  logic [2:0]  col_q, col_d, row_q, row_d;
  logic [9:0]  dx, dy;
  logic        in_board_d;
  logic        in_board_p0, de_p0, hs_p0, vs_p0;
  logic [3:0]  rd_p1;
  logic [5:0]  subx_p1, suby_p1, addr_p1;
  logic        in_board_p1, par_p1, de_p1, hs_p1, vs_p1;
  logic [11:0] colour_d;
  logic [11:0] rgb_q;
  logic        de_q, hs_q, vs_q;
  logic        vs_prev_q, frame_tick_q;
  logic [7:0]  frame_cnt_q;
  logic        vs_fall;

  // Offsets wrap to large values left of / above the board, so one compare suffices.
  assign dx         = bus.pix_x - X0;
  assign dy         = bus.pix_y - Y0;
  assign in_board_d = (dx < 10'd480) && (dy < 10'd480);

  // Next cell position: columns restart at the board's left column, rows at its first line.
  always_comb begin
    subx_d = subx_q;
    col_d  = col_q;
    suby_d = suby_q;
    row_d  = row_q;
    if (bus.pix_x == X0) begin
      subx_d = 6'd0;
      col_d  = 3'd0;
      if (bus.pix_y == Y0) begin
        suby_d = 6'd0;
        row_d  = 3'd0;
      end else if (suby_q == 6'd59) begin
        suby_d = 6'd0;
        row_d  = row_q + 3'd1;
      end else begin
        suby_d = suby_q + 6'd1;
      end
    end else if (subx_q == 6'd59) begin
      subx_d = 6'd0;
      col_d  = col_q + 3'd1;
    end else begin
      subx_d = subx_q + 6'd1;
    end
  end

  // Stage 1: cell tracking and timing capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      subx_q      <= '0;
      suby_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      in_board_p0 <= 1'b0;
      de_p0       <= 1'b0;
      hs_p0       <= 1'b1;
      vs_p0       <= 1'b1;
    end else begin
      subx_q      <= subx_d;
      suby_q      <= suby_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_board_p0 <= in_board_d;
      de_p0       <= bus.in_de;
      hs_p0       <= bus.hsync_in;
      vs_p0       <= bus.vsync_in;
    end
  end

  // Board memory: reset restores the opening position and blocks writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= start_piece(6'(i));
    end else if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Stage 2: read-first board lookup with cell geometry carried alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_p1       <= '0;
      subx_p1     <= '0;
      suby_p1     <= '0;
      addr_p1     <= '0;
      in_board_p1 <= 1'b0;
      par_p1      <= 1'b0;
      de_p1       <= 1'b0;
      hs_p1       <= 1'b1;
      vs_p1       <= 1'b1;
    end else begin
      rd_p1       <= mem_q[{row_q, col_q}];
      subx_p1     <= subx_q;
      suby_p1     <= suby_q;
      addr_p1     <= {row_q, col_q};
      in_board_p1 <= in_board_p0;
      par_p1      <= row_q[0] ^ col_q[0];
      de_p1       <= de_p0;
      hs_p1       <= hs_p0;
      vs_p1       <= vs_p0;
    end
  end

  // Colour priority: blanking, off-board, cursor, piece, selection, square.
  always_comb begin
    colour_d = par_p1 ? DARK_RGB : LIGHT_RGB;
    if (!de_p1 || !in_board_p1)
      colour_d = 12'h000;
    else if ((addr_p1 == bus.cursor_addr) && frame_cnt_q[BLINK_BIT] &&
             (edge_band(subx_p1) || edge_band(suby_p1)))
      colour_d = 12'hF00;
    else if (piece_hit(rd_p1[2:0], subx_p1, suby_p1))
      colour_d = rd_p1[3] ? 12'h111 : 12'hFFF;
    else if (bus.sel_valid && (addr_p1 == bus.sel_addr))
      colour_d = 12'h6C6;
  end

  // Stage 3: registered video outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= colour_d;
      de_q  <= de_p1;
      hs_q  <= hs_p1;
      vs_q  <= vs_p1;
    end
  end

  assign vs_fall = vs_prev_q && !bus.vsync_in;

  // Frame counter advances on each vsync falling edge and drives cursor blink.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q    <= 1'b1;
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_prev_q    <= bus.vsync_in;
      frame_cnt_q  <= frame_cnt_q + {7'd0, vs_fall};
      frame_tick_q <= vs_fall;
    end
  end

  assign bus.rgb_out    = rgb_q;
  assign bus.de_out     = de_q;
  assign bus.hsync_out  = hs_q;
  assign bus.vsync_out  = vs_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
